// File: rtl/stack_controller.sv
// Multi-cycle control unit for an 8-bit stack machine: a Moore FSM that sequences
// fetch, decode, stack pops/pushes, ALU execution, memory access and branches.
module stack_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inst,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcSrc,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IrWrite,
  output logic       MtoS,
  output logic       ldA,
  output logic       ldB,
  output logic       srcA,
  output logic       srcB,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic [1:0] AluOp
);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_POPA, S_POPB, S_EXEC, S_PUSHR,
    S_MEMRD, S_PUSHM, S_MEMWR, S_JMP, S_TOSR, S_JZCHK
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       m_to_s;
    logic       ld_a;
    logic       ld_b;
    logic       src_a;
    logic       src_b;
    logic       push;
    logic       pop;
    logic       tos;
    logic [1:0] alu_op;
  } ctl_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] op;
  logic [2:0] op_nxt;
  ctl_t       ctl;

  // The address field is routed to the datapath IR; only the opcode matters here.
  logic unused_addr;
  assign unused_addr = ^inst[4:0];

  // Control word for a state; unknown encodings yield an all-zero word.
  function automatic ctl_t decode(input state_t s, input logic [2:0] o);
    ctl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.src_a    = 1'b1;
        c.src_b    = 1'b1;
        c.pc_write = 1'b1;
      end
      S_ID: ;
      S_POPA: begin
        c.pop  = 1'b1;
        c.ld_a = 1'b1;
      end
      S_POPB: begin
        c.pop  = 1'b1;
        c.ld_b = 1'b1;
      end
      S_EXEC:  c.alu_op = o[1:0];
      S_PUSHR: c.push = 1'b1;
      S_MEMRD: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      S_PUSHM: begin
        c.push   = 1'b1;
        c.m_to_s = 1'b1;
      end
      S_MEMWR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_JMP: begin
        c.pc_src   = 1'b1;
        c.pc_write = 1'b1;
      end
      S_TOSR: c.tos = 1'b1;
      S_JZCHK: begin
        c.pc_src        = 1'b1;
        c.pc_write_cond = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = S_IF;
    op_nxt    = op;
    case (state)
      S_IF: begin
        state_nxt = S_ID;
        op_nxt    = inst[7:5];
      end
      S_ID: begin
        case (op)
          3'b100:  state_nxt = S_MEMRD;
          3'b110:  state_nxt = S_JMP;
          3'b111:  state_nxt = S_TOSR;
          default: state_nxt = S_POPA;
        endcase
      end
      S_POPA: begin
        case (op)
          3'b000, 3'b001, 3'b010: state_nxt = S_POPB;
          3'b011:                 state_nxt = S_EXEC;
          3'b101:                 state_nxt = S_MEMWR;
          default:                state_nxt = S_IF;
        endcase
      end
      S_POPB:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_PUSHR;
      S_MEMRD: state_nxt = S_PUSHM;
      S_TOSR:  state_nxt = S_JZCHK;
      default: state_nxt = S_IF;
    endcase
  end

  // Outputs are registered from the upcoming state so they stay Moore-clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IF;
      op    <= 3'b000;
      ctl   <= decode(S_IF, 3'b000);
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      ctl   <= decode(state_nxt, op_nxt);
    end
  end

  assign pcWrite     = ctl.pc_write;
  assign pcWriteCond = ctl.pc_write_cond;
  assign pcSrc       = ctl.pc_src;
  assign IorD        = ctl.i_or_d;
  assign memRead     = ctl.mem_read;
  assign memWrite    = ctl.mem_write;
  assign IrWrite     = ctl.ir_write;
  assign MtoS        = ctl.m_to_s;
  assign ldA         = ctl.ld_a;
  assign ldB         = ctl.ld_b;
  assign srcA        = ctl.src_a;
  assign srcB        = ctl.src_b;
  assign push        = ctl.push;
  assign pop         = ctl.pop;
  assign tos         = ctl.tos;
  assign AluOp       = ctl.alu_op;

endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 The module SHALL have no parameters; instruction width 8, opcode inst[7:5], address field inst[4:0] (consumed by datapath IR, not here).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 inst  input  8  memory read data of the datapath (instruction word while fetching).
REQ-005 pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IrWrite, MtoS  output  1 each  datapath controls: unconditional PC load, PC load if zero flag, PC source select (1=IR[4:0]), address select (1=IR[4:0]), memory read, memory write, IR load, stack-input select (1=MDR).
REQ-006 ldA, ldB, srcA, srcB, push, pop, tos  output  1 each  A/B load, ALU A select (1=PC), ALU B select (1=constant 1), stack push, stack pop, stack top-read.
REQ-007 AluOp  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT.

Function
REQ-008 Controller SHALL be a Moore FSM, 12 states: IF, ID, POPA, POPB, EXEC, PUSHR, MEMRD, PUSHM, MEMWR, JMP, TOSR, JZCHK; outputs decoded from state and internal opcode register only.
REQ-009 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr; all eight legal.
REQ-010 Internal 3-bit opcode register SHALL load inst[7:5] on the rising edge ending IF; held in all other states.
REQ-011 Every output not listed for a state SHALL be 0; AluOp SHALL be 00 unless listed.
REQ-012 IF: IorD=0, memRead=1, IrWrite=1, srcA=1, srcB=1, AluOp=00, pcSrc=0, pcWrite=1 (PC<=PC+1); next ID.
REQ-013 ID: no outputs; next POPA for 000-011 and 101, MEMRD for 100, JMP for 110, TOSR for 111.
REQ-014 POPA: pop=1, ldA=1; next POPB for 000-010, EXEC for 011, MEMWR for 101.
REQ-015 POPB: pop=1, ldB=1; next EXEC.
REQ-016 EXEC: srcA=0, srcB=0, AluOp=opcode[1:0] (ALU result register captures); next PUSHR.
REQ-017 PUSHR: push=1, MtoS=0; next IF.
REQ-018 MEMRD: IorD=1, memRead=1 (MDR captures); next PUSHM. PUSHM: push=1, MtoS=1; next IF.
REQ-019 MEMWR: IorD=1, memWrite=1 (mem[IR[4:0]]<=A); next IF.
REQ-020 JMP: pcSrc=1, pcWrite=1; next IF.
REQ-021 TOSR: tos=1 (zero flag updates from stack top, stack unchanged); next JZCHK. JZCHK: pcSrc=1, pcWriteCond=1; next IF.
REQ-022 Instruction latency SHALL be: ADD/SUB/AND 6 cycles, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4 (IF through last state inclusive).
REQ-023 push and pop SHALL never both be 1; memRead and memWrite SHALL never both be 1; pcWrite and pcWriteCond SHALL never both be 1.
REQ-024 Unreachable state encodings SHALL transition to IF on the next edge with all outputs 0.

Reset
REQ-025 On rst=1 the FSM SHALL enter IF and the opcode register SHALL clear to 000 immediately, independent of clk.
REQ-026 While rst=1 and after release, outputs SHALL equal IF outputs: memRead=1, IrWrite=1, srcA=1, srcB=1, pcWrite=1, all others 0, AluOp=00.
REQ-027 Reset asserted in any state SHALL abort the instruction; no partial push/pop/write issued after the asserting edge.
REQ-028 First rising edge after rst deasserts SHALL complete IF and move to ID.

Verification
REQ-029 Reset: rst pulse mid-EXEC of ADD -> outputs immediately IF values; next edge ID; no PUSHR cycle observed.
REQ-030 ADD: inst=8'h00 at IF -> state sequence IF,ID,POPA,POPB,EXEC(AluOp=00),PUSHR(push=1,MtoS=0),IF; 6 cycles.
REQ-031 NOT/SUB: inst=8'h60 -> POPB skipped, EXEC AluOp=11; inst=8'h20 -> EXEC AluOp=01, 6 cycles.
REQ-032 PUSH/POP: inst=8'h85 -> MEMRD(IorD=1,memRead=1), PUSHM(push=1,MtoS=1); inst=8'hA5 -> POPA, MEMWR(IorD=1,memWrite=1); 4 cycles each.
REQ-033 Branches: inst=8'hC3 -> JMP with pcSrc=1,pcWrite=1, 3 cycles; inst=8'hE3 -> TOSR(tos=1), JZCHK(pcWriteCond=1,pcWrite=0), 4 cycles.
REQ-034 Exclusivity: random 1000-instruction stream -> REQ-023 pairs never simultaneously 1; inst changes outside IF never alter the sequence.
